// File: rtl/wordpanel_pkg.sv
// Shared types and default geometry for the word-panel column scan path.
package wordpanel_pkg;

    localparam int DEF_N_COLS = 24;
    localparam int DEF_N_ROWS = 8;
    localparam int DEF_DWELL  = 16;
    localparam int DEF_BLANK  = 2;

    typedef logic [$clog2(DEF_N_COLS)-1:0] col_idx_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_DISPLAY = 3'd2,
        S_BLANK   = 3'd3,
        S_ADVANCE = 3'd4
    } scan_state_t;

endpackage

// File: rtl/col_scan_driver_onehot_to_idx.sv
// One-hot to binary encoder; o_valid only when exactly one input bit is set.
module onehot_to_idx #(
    parameter int N  = 24,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_vec,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [IW-1:0] w_acc;

    assign o_valid = (i_vec != '0) && ((i_vec & (i_vec - 1'b1)) == '0);

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < N; i++) begin
            if (i_vec[i]) begin
                w_acc = w_acc | IW'(i);
            end
        end
    end

    // Forced to zero when invalid so the frame read never leaves the array.
    assign o_idx = o_valid ? w_acc : '0;

endmodule

// File: rtl/col_scan_driver.sv
// Column scan driver: per column LOAD, DISPLAY for DWELL cycles, BLANK, then
// ADVANCE pulses shift_req. Pixel data comes from a double-buffered frame store.
module col_scan_driver #(
    parameter int N_COLS = wordpanel_pkg::DEF_N_COLS,
    parameter int N_ROWS = wordpanel_pkg::DEF_N_ROWS,
    parameter int DWELL  = wordpanel_pkg::DEF_DWELL,
    parameter int BLANK  = wordpanel_pkg::DEF_BLANK
) (
    input  logic                      clk,
    input  logic                      CLR_n,
    input  logic                      en,
    input  logic [N_COLS-1:0]         active_col,
    input  logic                      fb_we,
    input  logic [$clog2(N_COLS)-1:0] fb_waddr,
    input  logic [N_ROWS-1:0]         fb_wdata,
    input  logic                      swap,
    output logic                      shift_req,
    output logic [N_ROWS-1:0]         rows,
    output logic                      col_en,
    output logic                      frame_done,
    output logic                      err_onehot,
    output logic [2:0]                dbg_state
);

    import wordpanel_pkg::*;

    localparam int IW = $clog2(N_COLS);
    localparam int CW = $clog2(((DWELL > BLANK) ? DWELL : BLANK) + 1);
    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LD = CW'(BLANK - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_COLS - 1);

    scan_state_t       r_state;
    scan_state_t       w_next;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic              r_col_ok;
    logic [N_ROWS-1:0] r_rows;
    logic              r_err;
    logic              r_front;
    logic              r_swap_pend;
    logic [N_ROWS-1:0] r_bank0 [N_COLS];
    logic [N_ROWS-1:0] r_bank1 [N_COLS];

    logic [IW-1:0]     w_idx;
    logic              w_valid;
    logic              w_wrap;
    logic              w_wr_ok;
    logic [N_ROWS-1:0] w_front_word;

    onehot_to_idx #(.N(N_COLS), .IW(IW)) u_enc (
        .i_vec   (active_col),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (en) w_next = S_LOAD;
            S_LOAD:    w_next = S_DISPLAY;
            S_DISPLAY: if (r_cnt == '0) w_next = S_BLANK;
            S_BLANK:   if (r_cnt == '0) w_next = en ? S_ADVANCE : S_IDLE;
            S_ADVANCE: w_next = S_LOAD;
            default:   w_next = S_IDLE;
        endcase
    end

    // Outputs decode from the state register so an async clear drops them at once.
    assign shift_req    = (r_state == S_ADVANCE);
    assign w_wrap       = shift_req && r_col_ok && (r_idx == LAST_IDX);
    assign frame_done   = w_wrap;
    assign col_en       = (r_state == S_DISPLAY) && r_col_ok;
    assign rows         = col_en ? r_rows : '0;
    assign err_onehot   = r_err;
    assign dbg_state    = r_state;
    assign w_front_word = r_front ? r_bank1[w_idx] : r_bank0[w_idx];
    assign w_wr_ok      = int'(fb_waddr) < N_COLS;

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_col_ok    <= 1'b0;
            r_rows      <= '0;
            r_err       <= 1'b0;
            r_front     <= 1'b0;
            r_swap_pend <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_LOAD: begin
                    r_cnt    <= DWELL_LD;
                    r_col_ok <= w_valid;
                    if (w_valid) begin
                        r_idx  <= w_idx;
                        r_rows <= w_front_word;
                    end else begin
                        r_rows <= '0;
                        r_err  <= 1'b1;
                    end
                end
                S_DISPLAY: r_cnt <= (r_cnt == '0) ? BLANK_LD : r_cnt - 1'b1;
                S_BLANK:   if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                default:   ;
            endcase
            if (w_wrap && r_swap_pend) begin
                r_front <= ~r_front;
            end
            // A swap arriving on the wrap edge re-arms for the following frame.
            r_swap_pend <= (r_swap_pend && !w_wrap) || swap;
        end
    end

    // Writes always target the bank that is back on this edge.
    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            for (int i = 0; i < N_COLS; i++) begin
                r_bank0[i] <= '0;
                r_bank1[i] <= '0;
            end
        end else if (fb_we && w_wr_ok) begin
            if (r_front) begin
                r_bank0[fb_waddr] <= fb_wdata;
            end else begin
                r_bank1[fb_waddr] <= fb_wdata;
            end
        end
    end

endmodule
